// File: rtl/beta_trace_rec.sv
// beta_trace_rec: passive trace recorder for the Beta core.
// Captures one 68-bit record per clk while in CAPTURE:
//   {irq, reset, MemRead, MemWrite, ia[31:0], memAddr[31:0]}
// into an on-chip buffer, then drains it oldest-first through a
// show-ahead valid/ready port while in HOLD.
// Optional feature macro: TRACE_WRAP_EN
//   defined   -> ring mode: a write into a full buffer overwrites the
//                oldest record and sets the sticky overflow flag.
//   undefined -> stop-on-full: the write that fills the buffer forces
//                HOLD; overflow is constant 0.
module beta_trace_rec #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          arm,
    input  logic          stop,
    input  logic          tr_irq,
    input  logic          tr_reset,
    input  logic          tr_MemRead,
    input  logic          tr_MemWrite,
    input  logic [31:0]   tr_ia,
    input  logic [31:0]   tr_memAddr,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [67:0]   rd_data,
    output logic [AW:0]   count,
    output logic          full,
    output logic          overflow,
    output logic          capturing
);

    localparam int RW = 68;

    localparam logic [AW:0] DEPTH_CNT      = (AW+1)'(DEPTH);
    localparam logic [AW:0] DEPTH_CNT_M1   = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0] CNT_ONE        = (AW+1)'(1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_HOLD    = 2'd2;

    // Control state
    logic [1:0]    r_state;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_overflow;

    logic [1:0]    w_state_next;
    logic [AW-1:0] w_wr_ptr_next;
    logic [AW-1:0] w_rd_ptr_next;
    logic [AW:0]   w_count_next;
    logic          w_overflow_next;
    logic          w_wr_en;
    logic [RW-1:0] w_wr_data;
    logic          w_pop;

    // Trace storage with registered read plus a write-through bypass
    logic [RW-1:0] r_mem [DEPTH];
    logic [RW-1:0] r_mem_q;
    logic [RW-1:0] r_byp_data;
    logic          r_byp;
    logic          w_byp;

    assign w_wr_data = {tr_irq, tr_reset, tr_MemRead, tr_MemWrite, tr_ia, tr_memAddr};

    // Next-state, pointer and occupancy computation
    always_comb begin
        w_state_next    = r_state;
        w_wr_ptr_next   = r_wr_ptr;
        w_rd_ptr_next   = r_rd_ptr;
        w_count_next    = r_count;
        w_overflow_next = r_overflow;
        w_wr_en         = 1'b0;
        w_pop           = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // stop arriving with arm is deliberately ignored here
                if (arm) begin
                    w_state_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                w_wr_en       = 1'b1;
                w_wr_ptr_next = r_wr_ptr + 1'b1;
`ifdef TRACE_WRAP_EN
                if (r_count == DEPTH_CNT) begin
                    // oldest record is overwritten, so the read side slides along
                    w_rd_ptr_next   = r_rd_ptr + 1'b1;
                    w_overflow_next = 1'b1;
                end else begin
                    w_count_next = r_count + 1'b1;
                end
                if (stop) begin
                    w_state_next = ST_HOLD;
                end
`else
                w_count_next = r_count + 1'b1;
                // the filling write behaves like an implicit stop
                if (stop || (r_count == DEPTH_CNT_M1)) begin
                    w_state_next = ST_HOLD;
                end
`endif
            end
            ST_HOLD: begin
                if (r_count == '0) begin
                    w_state_next = ST_IDLE;
                end else if (rd_ready) begin
                    w_pop         = 1'b1;
                    w_rd_ptr_next = r_rd_ptr + 1'b1;
                    w_count_next  = r_count - 1'b1;
                    if (r_count == CNT_ONE) begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // A read of the slot being written this same edge must see the new record
    assign w_byp = w_wr_en && (r_wr_ptr == w_rd_ptr_next);

    // Control registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_wr_ptr   <= w_wr_ptr_next;
            r_rd_ptr   <= w_rd_ptr_next;
            r_count    <= w_count_next;
            r_overflow <= w_overflow_next;
        end
    end

    // Buffer write port and prefetching read port (no reset: RAM contents are don't-care)
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= w_wr_data;
        end
        r_mem_q    <= r_mem[w_rd_ptr_next];
        r_byp      <= w_byp;
        r_byp_data <= w_wr_data;
    end

    // Output decode; rd_data is forced to zero whenever nothing is offered
    always_comb begin
        rd_valid  = (r_state == ST_HOLD) && (r_count != '0);
        rd_data   = '0;
        if (rd_valid) begin
            rd_data = r_byp ? r_byp_data : r_mem_q;
        end
        count     = r_count;
        full      = (r_count == DEPTH_CNT);
        overflow  = r_overflow;
        capturing = (r_state == ST_CAPTURE);
    end

endmodule

// File: tb/tb_beta_trace_rec.sv
// Testbench for beta_trace_rec (DEPTH=4): vector table, directed corner
// sequences and a randomized run against a queue-based reference model.
module tb_beta_trace_rec;

    localparam int DEPTH = 4;
    localparam int AW    = 2;
`ifdef TRACE_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic          arm;
    logic          stop;
    logic          tr_irq;
    logic          tr_reset;
    logic          tr_MemRead;
    logic          tr_MemWrite;
    logic [31:0]   tr_ia;
    logic [31:0]   tr_memAddr;
    logic          rd_valid;
    logic          rd_ready;
    logic [67:0]   rd_data;
    logic [AW:0]   count;
    logic          full;
    logic          overflow;
    logic          capturing;

    beta_trace_rec #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .arm(arm), .stop(stop),
        .tr_irq(tr_irq), .tr_reset(tr_reset), .tr_MemRead(tr_MemRead),
        .tr_MemWrite(tr_MemWrite), .tr_ia(tr_ia), .tr_memAddr(tr_memAddr),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .count(count), .full(full), .overflow(overflow), .capturing(capturing)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: a queue of records plus a coarse mode
    logic [67:0] mq[$];
    int          mmode;   // 0 idle, 1 recording, 2 draining
    bit          movf;

    task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic model_edge();
        logic [67:0] rec;
        rec = {tr_irq, tr_reset, tr_MemRead, tr_MemWrite, tr_ia, tr_memAddr};
        if (reset) begin
            mq.delete();
            mmode = 0;
            movf  = 1'b0;
        end else if (mmode == 0) begin
            if (arm) mmode = 1;
        end else if (mmode == 1) begin
            if (WRAP && mq.size() == DEPTH) begin
                void'(mq.pop_front());
                movf = 1'b1;
            end
            mq.push_back(rec);
            if (stop || (!WRAP && mq.size() == DEPTH)) mmode = 2;
        end else begin
            if (mq.size() == 0) mmode = 0;
            else if (rd_ready) begin
                void'(mq.pop_front());
                if (mq.size() == 0) mmode = 0;
            end
        end
    endtask

    task automatic check_model(input string tag);
        logic        ev;
        logic [67:0] ed;
        ev = (mmode == 2) && (mq.size() != 0);
        ed = ev ? mq[0] : 68'h0;
        check({tag, ".rd_valid"},  rd_valid,  ev);
        check({tag, ".rd_data"},   rd_data,   ed);
        check({tag, ".count"},     count,     68'(mq.size()));
        check({tag, ".full"},      full,      (mq.size() == DEPTH));
        check({tag, ".overflow"},  overflow,  movf);
        check({tag, ".capturing"}, capturing, (mmode == 1));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    typedef struct {
        logic        arm;
        logic        stop;
        logic        rdy;
        logic        mr;
        logic [31:0] ia;
        logic        e_valid;
        int          e_count;
        logic        e_capt;
        logic [68-1:0] e_data;
    } vec_t;

    vec_t tbl[11];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_ia;

        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 0, 1'b1, 68'h0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1, 1'b1, 68'h0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h4, 1'b0, 2, 1'b1, 68'h0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h8, 1'b1, 3, 1'b0, 68'h0_00000000_00000100};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 2, 1'b0, 68'h2_00000004_00000100};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1, 1'b0, 68'h0_00000008_00000100};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 0, 1'b0, 68'h0};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 0, 1'b1, 68'h0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'hC, 1'b1, 1, 1'b0, 68'h0_0000000C_00000100};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 0, 1'b0, 68'h0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 0, 1'b0, 68'h0};

        mmode = 0; movf = 1'b0;
        reset = 1'b1; arm = 1'b0; stop = 1'b0; rd_ready = 1'b0;
        tr_irq = 1'b0; tr_reset = 1'b0; tr_MemRead = 1'b0; tr_MemWrite = 1'b0;
        tr_ia = 32'h0; tr_memAddr = 32'h100;

        // Reset hold for two cycles
        for (int c = 0; c < 2; c++) begin
            tick();
            check("rst.rd_valid", rd_valid, 1'b0);
            check("rst.count", count, 68'h0);
            check("rst.full", full, 1'b0);
            check("rst.overflow", overflow, 1'b0);
            check("rst.capturing", capturing, 1'b0);
            check("rst.rd_data", rd_data, 68'h0);
        end
        reset = 1'b0;

        // Vector table: basic capture/drain, arm+stop together, bypass read
        for (int i = 0; i < 11; i++) begin
            arm = tbl[i].arm; stop = tbl[i].stop; rd_ready = tbl[i].rdy;
            tr_MemRead = tbl[i].mr; tr_ia = tbl[i].ia; tr_memAddr = 32'h100;
            tick();
            $display("vec %0d: valid=%0b count=%0d capt=%0b data=%h", i, rd_valid, count, capturing, rd_data);
            check($sformatf("vec%0d.rd_valid", i), rd_valid, tbl[i].e_valid);
            check($sformatf("vec%0d.count", i), count, 68'(tbl[i].e_count));
            check($sformatf("vec%0d.capturing", i), capturing, tbl[i].e_capt);
            check($sformatf("vec%0d.rd_data", i), rd_data, tbl[i].e_data);
        end
        arm = 1'b0; stop = 1'b0; rd_ready = 1'b0; tr_MemRead = 1'b0;

        // Full handling: six capture cycles, stop on the sixth
        arm = 1'b1;
        tick(); check_model("full.arm");
        arm = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tr_ia = 32'(4 * k);
            stop  = (k == 5);
            tick();
            $display("full cyc %0d: count=%0d full=%0b ovf=%0b capt=%0b", k, count, full, overflow, capturing);
            check_model($sformatf("full%0d", k));
        end
        stop = 1'b0;
        check("full.count", count, 68'd4);
        check("full.full", full, 1'b1);
        check("full.overflow", overflow, 68'(WRAP));
        check("full.capturing", capturing, 1'b0);

        // Back-pressure: head record stays put while rd_ready is low
        exp_ia = WRAP ? 32'h8 : 32'h0;
        for (int s = 0; s < 3; s++) begin
            tick();
            $display("stall %0d: valid=%0b ia=%h count=%0d", s, rd_valid, rd_data[63:32], count);
            check("stall.ia", rd_data[63:32], exp_ia);
            check("stall.count", count, 68'd4);
        end
        for (int j = 0; j < 4; j++) begin
            check($sformatf("drain%0d.ia", j), rd_data[63:32], exp_ia + 32'(4 * j));
            rd_ready = 1'b1;
            tick();
            $display("drain %0d: count=%0d", j, count);
            check($sformatf("drain%0d.count", j), count, 68'(3 - j));
            check_model($sformatf("drain%0d", j));
        end
        rd_ready = 1'b0;
        check("drained.capturing", capturing, 1'b0);
        check("drained.rd_valid", rd_valid, 1'b0);

        // Reset in the middle of a drain, then a fresh capture
        arm = 1'b1; tick(); arm = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tr_ia = 32'h20 + 32'(4 * k);
            stop  = (k == 2);
            tick();
        end
        stop = 1'b0;
        rd_ready = 1'b1; tick(); check_model("mid.pop");
        reset = 1'b1; rd_ready = 1'b0; tick();
        $display("mid reset: count=%0d valid=%0b capt=%0b", count, rd_valid, capturing);
        check("midrst.count", count, 68'h0);
        check("midrst.rd_valid", rd_valid, 1'b0);
        check("midrst.capturing", capturing, 1'b0);
        reset = 1'b0;
        arm = 1'b1; tick(); arm = 1'b0;
        tr_ia = 32'h30; tr_MemWrite = 1'b1; stop = 1'b1; tick();
        stop = 1'b0; tr_MemWrite = 1'b0;
        check("rearm.rd_data", rd_data, 68'h1_00000030_00000100);
        check_model("rearm");
        rd_ready = 1'b1; tick();
        check("rearm.count", count, 68'h0);
        rd_ready = 1'b0;

        // Randomized traffic against the model
        for (int r = 0; r < 800; r++) begin
            reset       = ($urandom_range(0, 99) == 0);
            arm         = ($urandom_range(0, 3) == 0);
            stop        = ($urandom_range(0, 5) == 0);
            rd_ready    = $urandom_range(0, 1) == 1;
            tr_irq      = $urandom_range(0, 1) == 1;
            tr_reset    = $urandom_range(0, 1) == 1;
            tr_MemRead  = $urandom_range(0, 1) == 1;
            tr_MemWrite = $urandom_range(0, 1) == 1;
            tr_ia       = $urandom;
            tr_memAddr  = $urandom;
            tick();
            check_model($sformatf("rnd%0d", r));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
